// File: rtl/fma_line_cache.sv
// fma_line_cache: line store that assembles, captures and streams FMA operand lines
module fma_line_cache #(
  parameter int FMA_COUNT = 2,
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH = 375,
  parameter int READ_LATENCY = 2,
  localparam int LINE_WIDTH = 3*FMA_COUNT*WORD_WIDTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [31:0]           instr_in,
  input  logic                  instr_valid_in,
  output logic                  instr_ready_out,
  input  logic [LINE_WIDTH-1:0] write_buffer_read_in,
  input  logic                  write_buffer_valid_in,
  output logic                  write_buffer_ready_out,
  output logic [LINE_WIDTH-1:0] abc_out,
  output logic                  abc_valid_out,
  output logic                  use_new_c_out,
  output logic                  fma_output_can_be_valid_out,
  output logic                  idle_out,
  output logic                  load_imm_error_out,
  output logic                  op_code_error_out,
  output logic                  addr_error_out
);
  localparam int WORDS = 3*FMA_COUNT;
  localparam int WB = $clog2(WORDS);
  typedef enum logic {IDLE, WAIT_BUF} state_t;
  state_t state, state_nx;
  logic [3:0] op, reg_a, reg_b;
  logic [15:0] imm;
  logic accept, imm_bad, is_sma, is_loadi, is_sendl, is_loadb, is_writeb, op_bad, wr_en;
  logic [LINE_WIDTH-1:0] mem [DEPTH];
  logic [LINE_WIDTH-1:0] d [READ_LATENCY];
  logic [LINE_WIDTH-1:0] wr_data;
  logic [0:WORDS-1][WORD_WIDTH-1:0] staging;
  logic [ADDR_WIDTH-1:0] sma_addr, hold_addr, wr_addr, rd_addr;
  logic [READ_LATENCY:0] pv, pn, pf;
  logic unused_ok;
  assign op = instr_in[31:28];
  assign reg_a = instr_in[27:24];
  assign imm = instr_in[23:8];
  assign reg_b = instr_in[7:4];
  assign unused_ok = ^instr_in[3:0];
  assign instr_ready_out = state == IDLE;
  assign accept = instr_valid_in && instr_ready_out;
  assign imm_bad = imm >= 16'(DEPTH);
  assign is_sma = accept && op == 4'b0110;
  assign is_loadi = accept && op == 4'b0111;
  assign is_sendl = accept && op == 4'b1000;
  assign is_loadb = accept && op == 4'b1001;
  assign is_writeb = accept && op == 4'b1010;
  assign op_bad = accept && !(op inside {4'b0000, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010});
  assign idle_out = state == IDLE && pv == '0 && !abc_valid_out && !accept;
  // Next state and the single storage write port (SENDL, immediate LOADB or deferred capture)
  always_comb begin
    state_nx = state;
    wr_en = 1'b0;
    wr_addr = sma_addr;
    wr_data = staging;
    write_buffer_ready_out = 1'b0;
    if (state == WAIT_BUF || (is_loadb && !imm_bad)) begin
      wr_addr = state == WAIT_BUF ? hold_addr : imm[ADDR_WIDTH-1:0];
      wr_data = write_buffer_read_in;
      wr_en = write_buffer_valid_in;
      write_buffer_ready_out = write_buffer_valid_in;
      state_nx = write_buffer_valid_in ? IDLE : WAIT_BUF;
    end else if (is_sendl) wr_en = 1'b1;
  end
  // Control state, staging line, read pipeline tags, output registers and sticky errors
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      staging <= '0;
      sma_addr <= '0;
      hold_addr <= '0;
      pv <= '0;
      pn <= '0;
      pf <= '0;
      abc_out <= '0;
      abc_valid_out <= 1'b0;
      use_new_c_out <= 1'b0;
      fma_output_can_be_valid_out <= 1'b0;
      load_imm_error_out <= 1'b0;
      op_code_error_out <= 1'b0;
      addr_error_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (is_sma && !imm_bad) sma_addr <= imm[ADDR_WIDTH-1:0];
      if (is_loadi && reg_a < 4'(WORDS)) staging[reg_a[WB-1:0]] <= WORD_WIDTH'(imm);
      if (is_sendl) staging <= '0;
      if (is_loadb) hold_addr <= imm[ADDR_WIDTH-1:0];
      pv <= {pv[READ_LATENCY-1:0], is_writeb && !imm_bad};
      pn <= {pn[READ_LATENCY-1:0], reg_a == 4'd1};
      pf <= {pf[READ_LATENCY-1:0], reg_b == 4'd1};
      abc_valid_out <= pv[READ_LATENCY];
      if (pv[READ_LATENCY]) begin
        abc_out <= d[READ_LATENCY-1];
        use_new_c_out <= pn[READ_LATENCY];
        fma_output_can_be_valid_out <= pf[READ_LATENCY];
      end
      load_imm_error_out <= load_imm_error_out | (is_loadi && reg_a >= 4'(WORDS));
      op_code_error_out <= op_code_error_out | op_bad;
      addr_error_out <= addr_error_out | ((is_sma || is_loadb || is_writeb) && imm_bad);
    end
  end
  // Block-RAM style storage: registered address, READ_LATENCY data stages, never reset
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_addr <= imm[ADDR_WIDTH-1:0];
    d[0] <= mem[rd_addr];
    for (int i = 1; i < READ_LATENCY; i++) d[i] <= d[i-1];
  end
endmodule

// File: tb/tb_fma_line_cache.sv
// tb_fma_line_cache: randomized and directed checks against a transaction-level model
module tb_fma_line_cache;
  localparam int FC = 2, WW = 16, DEPTH = 375, RL = 2, LW = 3*FC*WW, NW = 3*FC;
  localparam logic [3:0] NOP = 4'b0000, SMA = 4'b0110, LOADI = 4'b0111, SENDL = 4'b1000, LOADB = 4'b1001, WRITEB = 4'b1010;
  logic clk_in = 1'b0, rst_in;
  logic [31:0] instr_in;
  logic instr_valid_in, instr_ready_out, write_buffer_valid_in, write_buffer_ready_out;
  logic [LW-1:0] write_buffer_read_in, abc_out;
  logic abc_valid_out, use_new_c_out, fma_output_can_be_valid_out, idle_out;
  logic load_imm_error_out, op_code_error_out, addr_error_out;
  fma_line_cache #(.FMA_COUNT(FC), .WORD_WIDTH(WW), .DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .instr_in(instr_in), .instr_valid_in(instr_valid_in),
    .instr_ready_out(instr_ready_out), .write_buffer_read_in(write_buffer_read_in),
    .write_buffer_valid_in(write_buffer_valid_in), .write_buffer_ready_out(write_buffer_ready_out),
    .abc_out(abc_out), .abc_valid_out(abc_valid_out), .use_new_c_out(use_new_c_out),
    .fma_output_can_be_valid_out(fma_output_can_be_valid_out), .idle_out(idle_out),
    .load_imm_error_out(load_imm_error_out), .op_code_error_out(op_code_error_out),
    .addr_error_out(addr_error_out)
  );
  always #5 clk_in = ~clk_in;
  typedef struct { int due; logic [LW-1:0] line; bit nc; bit fv; } pulse_t;
  pulse_t q[$];
  logic [LW-1:0] m_mem [DEPTH];
  logic [WW-1:0] m_stg [NW];
  logic [LW-1:0] m_abc;
  int m_sma, m_hold, cyc, tests, fails;
  bit m_wait, m_lerr, m_oerr, m_aerr, m_pulse, m_nc, m_fv;
  task automatic chk(string tag, logic [LW-1:0] got, logic [LW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mk(logic [3:0] op, logic [3:0] ra, logic [15:0] imm, logic [3:0] rb);
    return {op, ra, imm, rb, 4'h0};
  endfunction
  function automatic logic [LW-1:0] stg_line();
    logic [LW-1:0] l = '0;
    for (int k = 0; k < NW; k++) l = {l[LW-WW-1:0], m_stg[k]};
    return l;
  endfunction
  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] l = '0;
    for (int k = 0; k < NW; k++) l = {l[LW-WW-1:0], WW'($urandom)};
    return l;
  endfunction
  task automatic model_reset();
    m_wait = 0; m_sma = 0; m_lerr = 0; m_oerr = 0; m_aerr = 0; m_pulse = 0;
    m_abc = '0; m_nc = 0; m_fv = 0;
    foreach (m_stg[k]) m_stg[k] = '0;
    q.delete();
  endtask
  task automatic cycle(input bit r, input bit v, input logic [31:0] ins, input bit wv, input logic [LW-1:0] wd);
    bit acc;
    logic [3:0] op, ra, rb;
    int imm;
    rst_in = r; instr_valid_in = v; instr_in = ins; write_buffer_valid_in = wv; write_buffer_read_in = wd;
    op = ins[31:28]; ra = ins[27:24]; imm = int'(ins[23:8]); rb = ins[7:4];
    acc = v && !m_wait;
    #2;
    chk("instr_ready", instr_ready_out, !m_wait);
    chk("wb_ready", write_buffer_ready_out, wv && (m_wait || (acc && op == LOADB && imm < DEPTH)));
    chk("idle", idle_out, !m_wait && q.size() == 0 && !m_pulse && !acc);
    @(posedge clk_in);
    cyc++;
    if (r) model_reset();
    else if (m_wait) begin
      if (wv) begin m_mem[m_hold] = wd; m_wait = 0; end
    end else if (v) begin
      case (op)
        NOP: ;
        SMA: if (imm >= DEPTH) m_aerr = 1; else m_sma = imm;
        LOADI: if (ra < NW) m_stg[ra] = ins[23:8]; else m_lerr = 1;
        SENDL: begin m_mem[m_sma] = stg_line(); foreach (m_stg[k]) m_stg[k] = '0; end
        LOADB: if (imm >= DEPTH) m_aerr = 1; else if (wv) m_mem[imm] = wd; else begin m_wait = 1; m_hold = imm; end
        WRITEB: if (imm >= DEPTH) m_aerr = 1; else q.push_back('{cyc + RL + 1, m_mem[imm], ra == 4'd1, rb == 4'd1});
        default: m_oerr = 1;
      endcase
    end
    #1;
    m_pulse = q.size() > 0 && q[0].due == cyc;
    if (m_pulse) begin
      m_abc = q[0].line; m_nc = q[0].nc; m_fv = q[0].fv;
      q.delete(0);
    end
    chk("abc_valid", abc_valid_out, m_pulse);
    chk("abc", abc_out, m_abc);
    chk("use_new_c", use_new_c_out, m_nc);
    chk("fma_valid", fma_output_can_be_valid_out, m_fv);
    chk("load_imm_err", load_imm_error_out, m_lerr);
    chk("op_code_err", op_code_error_out, m_oerr);
    chk("addr_err", addr_error_out, m_aerr);
  endtask
  task automatic issue(input logic [31:0] ins, input bit wv = 0, input logic [LW-1:0] wd = '0);
    cycle(0, 1, ins, wv, wd);
  endtask
  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 0, '0);
  endtask
  function automatic logic [15:0] pick_addr();
    int s = $urandom_range(0, 19);
    if (s < 16) return 16'($urandom_range(0, 15));
    if (s < 18) return 16'(DEPTH - 1);
    if (s == 18) return 16'(DEPTH);
    return 16'($urandom_range(DEPTH, 65535));
  endfunction
  initial begin
    logic [3:0] bad_ops [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    logic [3:0] op;
    tests = 0; fails = 0; cyc = 0;
    rst_in = 1; instr_valid_in = 0; instr_in = '0; write_buffer_valid_in = 0; write_buffer_read_in = '0;
    @(posedge clk_in); #1;
    model_reset();
    cycle(1, 0, 32'h0, 0, '0);
    cycle(1, 0, 32'h0, 0, '0);
    for (int a = 0; a < 16; a++) issue(mk(LOADB, 0, 16'(a), 0), 1, rnd_line());
    issue(mk(LOADB, 0, 16'(DEPTH - 1), 0), 1, rnd_line());
    issue(mk(SMA, 0, 16'd5, 0));
    for (int k = 0; k < NW; k++) issue(mk(LOADI, 4'(k), 16'(k + 1), 0));
    issue(mk(SENDL, 0, 16'd0, 0));
    issue(mk(WRITEB, 4'd1, 16'd5, 4'd1));
    quiet(RL + 2);
    chk("tp_line5", abc_out, 96'h0001_0002_0003_0004_0005_0006);
    chk("tp_new_c", use_new_c_out, 1'b1);
    for (int a = 0; a < 3; a++) issue(mk(WRITEB, 0, 16'(a), 0));
    quiet(RL + 3);
    issue(mk(LOADB, 0, 16'd7, 0), 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, mk(WRITEB, 0, 16'd7, 0), 0, '0);
    cycle(0, 0, 32'h0, 1, {NW{16'hAAAA}});
    issue(mk(WRITEB, 0, 16'd7, 0));
    quiet(RL + 2);
    chk("tp_loadb7", abc_out, {NW{16'hAAAA}});
    issue(mk(LOADI, 4'd6, 16'hFFFF, 0));
    issue(mk(4'b1111, 0, 16'd0, 0));
    issue(mk(WRITEB, 0, 16'd400, 0));
    quiet(RL + 2);
    chk("tp_errs", {load_imm_error_out, op_code_error_out, addr_error_out}, 3'b111);
    issue(mk(SENDL, 0, 16'd0, 0));
    issue(mk(WRITEB, 0, 16'd5, 0));
    quiet(RL + 2);
    chk("tp_staging_zero", abc_out, '0);
    issue(mk(WRITEB, 4'd1, 16'd3, 4'd1));
    cycle(1, 0, 32'h0, 0, '0);
    quiet(RL + 3);
    issue(mk(WRITEB, 0, 16'd3, 0));
    quiet(RL + 2);
    chk("tp_reset_keep", abc_out, m_mem[3]);
    for (int n = 0; n < 3000; n++) begin
      int s = $urandom_range(0, 19);
      logic [3:0] ra = 4'($urandom_range(0, 7)), rb = 4'($urandom_range(0, 2));
      logic [15:0] imm = pick_addr();
      if ($urandom_range(0, 299) == 0) begin cycle(1, 0, 32'h0, 0, '0); continue; end
      op = s < 2 ? NOP : s < 4 ? SMA : s < 8 ? LOADI : s < 10 ? SENDL : s < 13 ? LOADB : s < 19 ? WRITEB : bad_ops[$urandom_range(0, 9)];
      if (op == LOADI) imm = 16'($urandom);
      if (op == WRITEB) ra = 4'($urandom_range(0, 2));
      cycle(0, $urandom_range(0, 3) != 0, mk(op, ra, imm, rb), $urandom_range(0, 1) == 1, rnd_line());
    end
    quiet(RL + 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fma_line_cache.md
# fma_line_cache

Parametrised data cache sitting between the instruction decoder and the FMA array. It assembles lines from immediates, stores FMA write-buffer results, and streams operand lines (a, b, c per FMA) into the FMAs. It is a state-machine controller with a ready/valid instruction handshake, pipelined back-to-back WRITEB without NOP bubbles, a waiting LOADB, and sticky error flags.

## Interface
- FMA_COUNT, 2: FMAs fed per line; LINE_WIDTH = 3*FMA_COUNT*WORD_WIDTH (localparam)
- WORD_WIDTH, 16: bits per word
- DEPTH, 375: lines in storage; ADDR_WIDTH = $clog2(DEPTH) (localparam)
- READ_LATENCY, 2: internal block-RAM read latency, 1 or 2
- clk_in  in  1  single clock; all logic on rising edge
- rst_in  in  1  reset, synchronous, active-high
- instr_in  in  32  [31:28] opcode, [27:24] reg_a, [23:8] imm, [7:4] reg_b, [3:0] unused
- instr_valid_in  in  1  instruction present
- instr_ready_out  out  1  instruction accepted when valid&ready
- write_buffer_read_in  in  LINE_WIDTH  FMA result line
- write_buffer_valid_in  in  1  result line present
- write_buffer_ready_out  out  1  result line consumed this cycle
- abc_out  out  LINE_WIDTH  operand line; word k at bits [LINE_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH]; FMA i uses words 3i,3i+1,3i+2 = a,b,c
- abc_valid_out  out  1  one-cycle pulse per WRITEB
- use_new_c_out  out  1  sideband, aligned with abc_valid_out
- fma_output_can_be_valid_out  out  1  sideband, aligned with abc_valid_out
- idle_out  out  1  no work pending or in flight
- load_imm_error_out, op_code_error_out, addr_error_out  out  1 each  sticky error flags

## Operation
- Opcodes: NOP 0000, SMA 0110, LOADI 0111, SENDL 1000, LOADB 1001, WRITEB 1010. Any other opcode sets op_code_error_out and is otherwise ignored.
- States: IDLE, WAIT_BUF. In IDLE, instr_ready_out=1. In WAIT_BUF, instr_ready_out=0.
- SMA: sma_addr <= imm.
- LOADI: if reg_a < 3*FMA_COUNT, staging word reg_a <= imm; else set load_imm_error_out and leave staging unchanged.
- SENDL: write the staging line to sma_addr. Clear staging to 0 in the same cycle.
- LOADB imm: if write_buffer_valid_in is high in the accept cycle, write write_buffer_read_in to imm and assert write_buffer_ready_out that cycle. Otherwise go to WAIT_BUF and hold imm.
- WAIT_BUF: on the first cycle with write_buffer_valid_in high, write the line, assert write_buffer_ready_out, return to IDLE.
- WRITEB imm: issue a read of imm. Carry use_new_c = (reg_a==0001) and fma_valid = (reg_b==0001) through a shift pipeline matched to the read.
- SMA does not change on LOADB or WRITEB, which use their own imm.
- Address checks: imm >= DEPTH on SMA, LOADB or WRITEB sets addr_error_out; the operation is dropped with no write, no read and no pulse. SENDL uses sma_addr, which is always checked on SMA.
- idle_out = (state==IDLE) and read pipeline empty and no instruction accepted this cycle.

## Timing
- Instruction accepted at edge T (valid&ready).
- WRITEB: abc_valid_out high exactly in cycle T+READ_LATENCY+1, with abc_out, use_new_c_out and fma_output_can_be_valid_out valid in that same cycle.
- Back-to-back WRITEB in consecutive cycles gives consecutive pulses with no gap.
- abc_out and the sideband outputs hold their values between pulses.
- A write (SENDL or LOADB) at T followed by WRITEB of the same address at T+1 returns the new data.
- LOADB with buffer valid: one cycle, no stall. Otherwise it stalls until buffer valid, plus one cycle.
- write_buffer_ready_out is combinational: it is high only in a cycle where the line is captured.
- Reset values: all outputs 0 except instr_ready_out=1 and idle_out=1; state IDLE; staging=0; sma_addr=0; read pipeline flushed.
- Reset mid-WRITEB: no pulse emerges after reset. Storage contents are unaffected.
- Error flags clear only on reset.

## Test plan
- SMA 5; LOADI words 0..5 = 1..6; SENDL; WRITEB 5 (reg_a=1, reg_b=1) -> after READ_LATENCY+1 cycles, abc_out = 0x0001_0002_0003_0004_0005_0006, use_new_c_out=1, fma_output_can_be_valid_out=1, one pulse.
- WRITEB to lines 0,1,2 on consecutive cycles -> three consecutive abc_valid_out pulses carrying lines 0,1,2 in order. idle_out stays low until the last pulse.
- LOADB 7 with write_buffer_valid_in held low 4 cycles, then high with 0xAAAA… -> instr_ready_out low for those 4 cycles; one write_buffer_ready_out pulse; a following WRITEB 7 returns 0xAAAA….
- LOADI reg_a=6; opcode 1111; WRITEB imm=400 -> load_imm_error_out, op_code_error_out and addr_error_out set, no abc_valid_out, staging unchanged.
- Assert rst_in one cycle after a WRITEB is accepted -> no abc_valid_out. All outputs take their reset values. A later WRITEB of the same line returns the pre-reset data.
